apb_gpio_bridge: RTL
====================

Name: apb_gpio_bridge

Overview:
- APB slave front end that sits directly upstream of the 8-pin GPIO controller.
- Decodes paddr into pin number and config-bit index, then drives the controller's write/read request.
- Holds the request until the controller's done flag, releases it, and waits for done to clear.
- Completes the APB transfer with pready, prdata and pslverr.

Parameters:
- ADDR_W, 8, width of paddr; only bits [5:0] are decoded, higher bits must be zero.
- NUM_CFG, 6, number of valid config-bit indices (DIR, DATA, INTS0, INTS1, PUR, PDR).
- TIMEOUT_CYCLES, 16, cycles allowed for each wait on the controller (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  [2:0] pin number, [5:3] config index
- pwdata  in  32  bit 0 is the pin-config value written
- prdata  out  32  read data, valid while pready=1
- pready  out  1  transfer complete, single-cycle pulse
- pslverr  out  1  error response, valid only with pready
- gpio_write  out  1  write request to controller
- gpio_read  out  1  read request to controller
- gpio_pin  out  3  pin number to controller
- gpio_cfg  out  3  config index to controller
- gpio_wdata  out  1  write data to controller
- gpio_rdata  in  32  controller read data
- gpio_write_done  in  1  controller write acknowledge
- gpio_read_done  in  1  controller read acknowledge

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; all outputs 0, including prdata, pready, pslverr, gpio_* and the captured address/data. Reset mid-transfer abandons the transfer with no pready.
- All outputs are registered.
- IDLE: waits for psel=1 & penable=1. At that edge it captures paddr[2:0]→gpio_pin, paddr[5:3]→gpio_cfg, pwdata[0]→gpio_wdata and pwrite.
  - Invalid access → RESP_ERR. Invalid means paddr[5:3] ≥ NUM_CFG, or any paddr bit above [5] set.
  - Otherwise → REQ.
- REQ: drives gpio_write=pwrite or gpio_read=!pwrite; the two are never high together.
  - On the edge that samples the matching done=1: on a read, capture gpio_rdata into a data register; then → RELEASE.
  - A non-matching done is ignored.
- RELEASE: request deasserted. When the matching done is sampled 0 → RESP_OK. The controller clears done only after the request drops, so the next transfer cannot re-trigger on a stale done.
- RESP_OK: pready=1 and pslverr=0 for exactly one cycle. prdata = captured data on a read, 0 on a write. Then → IDLE; prdata returns to 0.
- RESP_ERR: pready=1, pslverr=1, prdata=0 for one cycle; no controller access occurs. Then → IDLE.
- Error latency: pready rises on the cycle right after the access-phase edge.
- OK latency: the number of controller-dependent cycles, plus one bridge cycle per handshake step.
- psel/penable dropping while the bridge is busy is protocol-illegal. The bridge still completes the captured transfer.
- A new access phase is accepted only in IDLE, never in the same cycle as pready.
- Width rules: pwdata[31:1] is ignored; gpio_rdata is passed through unmodified.

Optional Feature:
- Macro: APB_GPIO_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on entry to REQ and again on entry to RELEASE, and increments each cycle in those states.
  - Reaching TIMEOUT_CYCLES drops any request and goes to RESP_ERR. The pulse is pready=1, pslverr=1, prdata=0.
- Not defined: no counter exists; REQ and RELEASE wait indefinitely.

Decomposition:
- Package apb_gpio_pkg holds:
  - state encoding: IDLE, REQ, RELEASE, RESP_OK, RESP_ERR
  - field positions PIN_LSB=0 and CFG_LSB=3, both 3 bits wide
  - config index constants: DIR=0, DATA=1, INTS0=2, INTS1=3, PUR=4, PDR=5
- One sub-module is natural: apb_gpio_addr_dec. It is combinational: paddr → pin, cfg, addr_err.

Test Plan:
- Write paddr=0x0B (pin 3, cfg DATA), pwdata=1 → gpio_write held high until write_done, gpio_pin=3, gpio_cfg=1, gpio_wdata=1; later one pready pulse with pslverr=0.
- Read paddr=0x0B after the write, with the controller model returning 0x4B → prdata=0x0000004B during the pready cycle, gpio_read never overlaps gpio_write.
- Access paddr=0x30 (cfg 6) → pready=1, pslverr=1 on the next cycle; gpio_write and gpio_read stay 0 throughout.
- Controller model holds done high for 3 extra cycles after the request drops → pready waits until done=0 and fires exactly once.
- rst=0 asserted while in REQ → next cycle all outputs 0 and state IDLE; a subsequent write completes normally.
- With APB_GPIO_TIMEOUT_EN and a controller that never asserts done → pslverr pulse 16 cycles after entry to REQ, gpio_write drops.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the APB-to-GPIO bridge: FSM states,
// paddr field layout and the controller's config-bit indices.
package apb_gpio_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    RELEASE  = 3'd2,
    RESP_OK  = 3'd3,
    RESP_ERR = 3'd4
  } state_e;

  localparam int PIN_LSB = 0;
  localparam int CFG_LSB = 3;
  localparam int FIELD_W = 3;

  localparam logic [2:0] DIR   = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] INTS0 = 3'd2;
  localparam logic [2:0] INTS1 = 3'd3;
  localparam logic [2:0] PUR   = 3'd4;
  localparam logic [2:0] PDR   = 3'd5;

  // States in which the bridge is waiting on the controller.
  function automatic logic is_wait_state(state_e s);
    return (s == REQ) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/apb_gpio_addr_dec.sv
// Combinational paddr decoder: splits out pin and config index and flags
// addresses that name no config bit or set bits above the decoded field.
module apb_gpio_addr_dec
  import apb_gpio_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int NUM_CFG = 6
) (
  input  logic [ADDR_W-1:0] paddr,
  output logic [2:0]        pin,
  output logic [2:0]        cfg,
  output logic              addr_err
);

  logic upper_set;

  always_comb begin
    pin       = paddr[PIN_LSB +: FIELD_W];
    cfg       = paddr[CFG_LSB +: FIELD_W];
    upper_set = (paddr >> (CFG_LSB + FIELD_W)) != '0;
    addr_err  = upper_set || (int'(cfg) >= NUM_CFG);
  end

endmodule

// File: rtl/apb_gpio_bridge.sv
// APB slave bridging to the 8-pin GPIO controller's request/done handshake.
// Optional APB_GPIO_TIMEOUT_EN bounds each controller wait to TIMEOUT_CYCLES.
module apb_gpio_bridge
  import apb_gpio_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int NUM_CFG        = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              gpio_write,
  output logic              gpio_read,
  output logic [2:0]        gpio_pin,
  output logic [2:0]        gpio_cfg,
  output logic              gpio_wdata,
  input  logic [31:0]       gpio_rdata,
  input  logic              gpio_write_done,
  input  logic              gpio_read_done
);

  state_e      state_q, state_d;
  logic [2:0]  pin_q, pin_d, cfg_q, cfg_d;
  logic        wdata_q, wdata_d, write_q, write_d;
  logic [31:0] rdata_q, rdata_d, prdata_q, prdata_d;
  logic        pready_q, pready_d, pslverr_q, pslverr_d;
  logic        req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [2:0]  dec_pin, dec_cfg;
  logic        dec_err, done_match, timeout;
  logic        unused_pwdata;

  assign unused_pwdata = ^pwdata[31:1];

  apb_gpio_addr_dec #(.ADDR_W(ADDR_W), .NUM_CFG(NUM_CFG)) u_dec (
    .paddr    (paddr),
    .pin      (dec_pin),
    .cfg      (dec_cfg),
    .addr_err (dec_err)
  );

  // Only the done flag of the operation in flight counts.
  assign done_match = write_q ? gpio_write_done : gpio_read_done;

`ifdef APB_GPIO_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign timeout = is_wait_state(state_q) && ((wait_cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (is_wait_state(state_q))
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    cfg_d     = cfg_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    req_wr_d  = req_wr_q;
    req_rd_d  = req_rd_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          pin_d   = dec_pin;
          cfg_d   = dec_cfg;
          wdata_d = pwdata[0];
          write_d = pwrite;
          if (dec_err) begin
            state_d   = RESP_ERR;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d  = REQ;
            req_wr_d = pwrite;
            req_rd_d = !pwrite;
          end
        end
      end
      REQ: begin
        if (done_match) begin
          if (!write_q) rdata_d = gpio_rdata;
          req_wr_d = 1'b0;
          req_rd_d = 1'b0;
          state_d  = RELEASE;
        end else if (timeout) begin
          req_wr_d  = 1'b0;
          req_rd_d  = 1'b0;
          state_d   = RESP_ERR;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!done_match) begin
          state_d  = RESP_OK;
          pready_d = 1'b1;
          prdata_d = write_q ? 32'h0 : rdata_q;
        end else if (timeout) begin
          state_d   = RESP_ERR;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      RESP_OK:  state_d = IDLE;
      RESP_ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pin_q     <= '0;
      cfg_q     <= '0;
      wdata_q   <= 1'b0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      req_wr_q  <= 1'b0;
      req_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pin_q     <= pin_d;
      cfg_q     <= cfg_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      req_wr_q  <= req_wr_d;
      req_rd_q  <= req_rd_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign gpio_write = req_wr_q;
  assign gpio_read  = req_rd_q;
  assign gpio_pin   = pin_q;
  assign gpio_cfg   = cfg_q;
  assign gpio_wdata = wdata_q;

endmodule
